shared_bus_responder: RTL and testbench
=======================================

# shared_bus_responder

Memory-side responder at the far end of the L2 shared bus. Accepts line-sized operations issued by the L2 (ASCII `R` read, `W` writeback, `M` read-for-ownership, `I` invalidate) and runs a snoop window in which other caches report on `snoopBus`. It then services the request from a small internal backing store and returns a single-cycle response. It stands in for main memory and the bus arbiter in cache simulations.

## Interface
Parameters:
- `byteSelect`, 6, number of byte-offset address bits per line.
- `addrBits`, 32, request address width.
- `lineSize`, 512, data bits per line; width of the shared data bus.
- `memDepth`, 16, number of lines in the backing store (power of 2).
- `snoopCycles`, 2, snoop window length in cycles (≥1).
- `memLatency`, 4, memory access length in cycles (≥1).

Ports:
- `clock`, in, 1, single clock; all state changes on the rising edge.
- `reset`, in, 1, asynchronous, active-high.
- `opValid`, in, 1, request present.
- `operation`, in, 8, ASCII op code: `"R"`, `"W"`, `"M"` or `"I"`.
- `address`, in, `addrBits`, line address.
- `writeData`, in, `lineSize`, writeback data; used only for `W`.
- `opReady`, out, 1, responder can accept a request.
- `snoopBus`, in, 2, snoop result: 00 miss, 01 HIT, 10 HITM, 11 is treated as HITM.
- `readData`, out, `lineSize`, line returned with the response.
- `respValid`, out, 1, response strobe, one cycle.
- `respShared`, out, 1, another cache holds the line; qualified by `respValid`.
- `respRetry`, out, 1, request aborted because of HITM; the L2 must reissue it; qualified by `respValid`.
- `opError`, out, 1, one-cycle pulse when an unknown op code is accepted.

## Operation
- States: IDLE, SNOOP, MEM, RESP. All outputs are registered.
- Accept: `opValid && opReady` at edge k.
  - Latches `operation`, `address` and `writeData`.
  - Index `idx = address[byteSelect+$clog2(memDepth)-1 : byteSelect]`.
- Unknown op code:
  - Stays in IDLE.
  - `opError` = 1 for one cycle.
  - No response.
- IDLE → SNOOP for `R`, `M` and `I`. IDLE → MEM for `W`; writebacks skip the snoop window.
- SNOOP:
  - `snoopBus` is sampled on each of the `snoopCycles` edges following acceptance.
  - HIT and HITM flags are accumulated by OR across the window.
  - At the last sampling edge:
    - HITM seen and op is `R`, `M` or `I` → RESP with retry.
    - Otherwise `R`/`M` → MEM and `I` → RESP.
- MEM:
  - Lasts `memLatency` cycles, using a down-counter.
  - On the final edge, `R`/`M` load `readData = mem[idx]`.
  - On the final edge, `W` performs `mem[idx] = writeData` and loads `readData = 0`.
  - Then → RESP.
- RESP lasts exactly one cycle, then IDLE. During it:
  - `respValid` = 1.
  - `respShared` = 1 only for `R` with HIT seen and no HITM; always 0 for `M`, `W` and `I`.
  - `respRetry` = 1 only on the HITM abort; `readData` = 0 on retry.
- `I` and retry responses never touch memory.
- `opReady` = 1 only in IDLE; it is 0 from the accept edge until the edge that returns to IDLE.
- `readData` holds its value until the next response.

## Timing
- Reset, asynchronous:
  - State → IDLE.
  - `opReady` = 1; `respValid`, `respShared`, `respRetry` and `opError` = 0.
  - `readData` = 0; all `memDepth` lines = 0; counters and snoop flags = 0.
- Reset mid-operation aborts the operation: no response is produced, and a pending `W` is not written.
- Latency from accept edge k to the edge that raises `respValid` (S = `snoopCycles`, L = `memLatency`):

| Op | Response edge |
|---|---|
| `R`/`M` | k+S+L |
| `W` | k+L |
| `I` | k+S |
| Retry | k+S |

- `respValid` falls at the next edge. `opReady` rises on that same edge, so the next accept can happen no earlier than the edge after it.
- Back-to-back requests: minimum spacing between accepts is latency + 2 edges.
- `snoopBus` is ignored outside SNOOP. Input changes during MEM have no effect, because request fields are latched at accept.
- An address above `memDepth` lines wraps through `idx`.

## Test plan
- Reset, then `W` to `address=0x0000_0040` with `writeData = {16{32'hA5A5_0001}}` → `respValid` at k+4 with `readData=0`. A following `R` to the same address with `snoopBus=00` → `respValid` at k+6 with the written line, `respShared=0` and `respRetry=0`.
- `R` with `snoopBus=01` on one snoop cycle only → `respShared=1`. The same stimulus with op `M` → `respShared=0`.
- `R` with `snoopBus=10` on the second snoop cycle → `respValid` and `respRetry=1` at k+2, `readData=0`, and no MEM state is entered.
- `I` with `snoopBus=00` → response at k+2 with all flags 0; memory unchanged, verified by a later read.
- Operation `"X"` → `opError` pulses one cycle, `opReady` stays 1, no `respValid`. Address `0x0000_0400` aliases to idx 0.
- Assert `reset` 3 cycles into a `W` → no response and `opReady=1` immediately. A later read of that address returns 0.

Source files
------------

// File: rtl/shared_bus_responder.sv
// Memory-side responder for the L2 shared bus: snoop window, small backing store,
// single-cycle response with shared/retry flags.
module shared_bus_responder #(
  parameter int unsigned byteSelect  = 6,
  parameter int unsigned addrBits    = 32,
  parameter int unsigned lineSize    = 512,
  parameter int unsigned memDepth    = 16,
  parameter int unsigned snoopCycles = 2,
  parameter int unsigned memLatency  = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                opValid,
  input  logic [7:0]          operation,
  input  logic [addrBits-1:0] address,
  input  logic [lineSize-1:0] writeData,
  output logic                opReady,
  input  logic [1:0]          snoopBus,
  output logic [lineSize-1:0] readData,
  output logic                respValid,
  output logic                respShared,
  output logic                respRetry,
  output logic                opError
);

  localparam int unsigned IDX_W   = $clog2(memDepth);
  localparam int unsigned CNT_MAX = (snoopCycles > memLatency) ? snoopCycles : memLatency;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [7:0]  OP_R    = 8'h52;
  localparam logic [7:0]  OP_W    = 8'h57;
  localparam logic [7:0]  OP_M    = 8'h4D;
  localparam logic [7:0]  OP_I    = 8'h49;

  typedef enum logic [1:0] {S_IDLE, S_SNOOP, S_MEM, S_RESP} state_t;

  state_t              r_state, w_next_state;
  logic [7:0]          r_op;
  logic [IDX_W-1:0]    r_idx;
  logic [lineSize-1:0] r_wdata;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_hit, r_hitm;
  logic                r_op_ready, r_resp_valid, r_resp_shared, r_resp_retry, r_op_error;
  logic [lineSize-1:0] r_read_data;
  logic [lineSize-1:0] r_mem [memDepth];

  logic w_hit_now, w_hitm_now, w_known, w_unused;

  assign w_unused   = ^address;
  assign w_known    = (operation == OP_R) || (operation == OP_W) ||
                      (operation == OP_M) || (operation == OP_I);
  assign w_hit_now  = r_hit | (snoopBus == 2'b01);
  assign w_hitm_now = r_hitm | snoopBus[1];

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:
        if (opValid && w_known)
          w_next_state = (operation == OP_W) ? S_MEM : S_SNOOP;
      S_SNOOP:
        if (r_cnt == '0) begin
          if (w_hitm_now || (r_op == OP_I)) w_next_state = S_RESP;
          else                              w_next_state = S_MEM;
        end
      S_MEM:
        if (r_cnt == '0) w_next_state = S_RESP;
      S_RESP:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_op          <= '0;
      r_idx         <= '0;
      r_wdata       <= '0;
      r_cnt         <= '0;
      r_hit         <= 1'b0;
      r_hitm        <= 1'b0;
      r_op_ready    <= 1'b1;
      r_resp_valid  <= 1'b0;
      r_resp_shared <= 1'b0;
      r_resp_retry  <= 1'b0;
      r_op_error    <= 1'b0;
      r_read_data   <= '0;
      for (int unsigned i = 0; i < memDepth; i++) r_mem[i] <= '0;
    end else begin
      r_op_error   <= 1'b0;
      r_op_ready   <= (w_next_state == S_IDLE);
      r_resp_valid <= (w_next_state == S_RESP);
      case (r_state)
        S_IDLE:
          if (opValid) begin
            r_op    <= operation;
            r_idx   <= address[byteSelect +: IDX_W];
            r_wdata <= writeData;
            r_hit   <= 1'b0;
            r_hitm  <= 1'b0;
            if (!w_known)               r_op_error <= 1'b1;
            else if (operation == OP_W) r_cnt <= CNT_W'(memLatency - 1);
            else                        r_cnt <= CNT_W'(snoopCycles - 1);
          end
        S_SNOOP: begin
          r_hit  <= w_hit_now;
          r_hitm <= w_hitm_now;
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else if (w_next_state == S_MEM) begin
            r_cnt <= CNT_W'(memLatency - 1);
          end else begin
            // Retry and invalidate responses carry no line data.
            r_resp_retry  <= w_hitm_now;
            r_resp_shared <= 1'b0;
            r_read_data   <= '0;
          end
        end
        S_MEM:
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            r_resp_retry <= 1'b0;
            if (r_op == OP_W) begin
              r_mem[r_idx]  <= r_wdata;
              r_read_data   <= '0;
              r_resp_shared <= 1'b0;
            end else begin
              r_read_data   <= r_mem[r_idx];
              r_resp_shared <= (r_op == OP_R) && r_hit && !r_hitm;
            end
          end
        default: ;
      endcase
    end
  end

  assign opReady    = r_op_ready;
  assign respValid  = r_resp_valid;
  assign respShared = r_resp_shared;
  assign respRetry  = r_resp_retry;
  assign opError    = r_op_error;
  assign readData   = r_read_data;

endmodule

// File: tb/tb_shared_bus_responder.sv
// Directed bench for shared_bus_responder; expected responses are queued at issue
// and popped when respValid is observed.
module tb_shared_bus_responder;

  logic         clock = 1'b0;
  logic         reset;
  logic         opValid;
  logic [7:0]   operation;
  logic [31:0]  address;
  logic [511:0] writeData;
  logic         opReady;
  logic [1:0]   snoopBus;
  logic [511:0] readData;
  logic         respValid, respShared, respRetry, opError;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [511:0] data;
    logic         shared;
    logic         retry;
    logic         chk_data;
    int           lat;
  } exp_t;
  exp_t sb[$];

  localparam logic [511:0] D1 = {16{32'hA5A5_0001}};
  localparam logic [511:0] D2 = {16{32'h1234_5678}};
  localparam logic [511:0] D3 = {16{32'hDEAD_BEEF}};

  shared_bus_responder #(
    .byteSelect(6), .addrBits(32), .lineSize(512),
    .memDepth(16), .snoopCycles(2), .memLatency(4)
  ) dut (
    .clock(clock), .reset(reset), .opValid(opValid), .operation(operation),
    .address(address), .writeData(writeData), .opReady(opReady),
    .snoopBus(snoopBus), .readData(readData), .respValid(respValid),
    .respShared(respShared), .respRetry(respRetry), .opError(opError)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Issue one request, drive the two snoop samples, wait (bounded) for the response.
  task automatic run_op(input string tag, input logic [7:0] op, input logic [31:0] addr,
                        input logic [511:0] wd, input logic [1:0] s0, input logic [1:0] s1,
                        input int lat, input logic [511:0] exp_data, input logic exp_sh,
                        input logic exp_rt, input logic chk_data);
    exp_t e;
    int   n;
    bit   got;
    e.data = exp_data; e.shared = exp_sh; e.retry = exp_rt; e.chk_data = chk_data; e.lat = lat;
    sb.push_back(e);
    @(negedge clock);
    opValid = 1'b1; operation = op; address = addr; writeData = wd; snoopBus = s0;
    @(posedge clock);
    #1;
    opValid = 1'b0; operation = 8'h00; address = 32'hFFFF_FFC0; writeData = '1;
    chk({tag, "_ready_low"}, opReady, 0);
    n = 0; got = 0;
    while (n < 40 && !got) begin
      @(posedge clock);
      n++;
      #1;
      if (n == 1) snoopBus = s1;
      if (respValid) got = 1;
    end
    snoopBus = 2'b00;
    chk({tag, "_resp_seen"}, got, 1);
    e = sb.pop_front();
    if (got) begin
      chk({tag, "_latency"}, n, e.lat);
      chk({tag, "_shared"}, respShared, e.shared);
      chk({tag, "_retry"}, respRetry, e.retry);
      if (e.chk_data) chk({tag, "_data"}, readData, e.data);
      @(posedge clock);
      #1;
      chk({tag, "_valid_fall"}, respValid, 0);
      chk({tag, "_ready_rise"}, opReady, 1);
    end
  endtask

  initial begin
    int nresp;
    reset = 1'b1; opValid = 1'b0; operation = 8'h00; address = '0; writeData = '0; snoopBus = 2'b00;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_ready", opReady, 1);
    chk("rst_valid", respValid, 0);
    chk("rst_data", readData, 0);
    chk("rst_err", opError, 0);
    @(negedge clock);
    reset = 1'b0;

    run_op("w1",    "W", 32'h0000_0040, D1, 2'b00, 2'b00, 4, '0, 0, 0, 1);
    run_op("r1",    "R", 32'h0000_0040, '0, 2'b00, 2'b00, 6, D1, 0, 0, 1);
    run_op("r_hit", "R", 32'h0000_0040, '0, 2'b01, 2'b00, 6, D1, 1, 0, 1);
    run_op("m_hit", "M", 32'h0000_0040, '0, 2'b01, 2'b00, 6, D1, 0, 0, 1);
    run_op("r_hitm","R", 32'h0000_0040, '0, 2'b00, 2'b10, 2, '0, 0, 1, 1);
    run_op("r_s11", "R", 32'h0000_0040, '0, 2'b11, 2'b00, 2, '0, 0, 1, 1);
    run_op("r_hhm", "R", 32'h0000_0040, '0, 2'b01, 2'b10, 2, '0, 0, 1, 1);
    run_op("inv",   "I", 32'h0000_0040, '0, 2'b00, 2'b00, 2, '0, 0, 0, 0);
    run_op("inv_h", "I", 32'h0000_0040, '0, 2'b01, 2'b00, 2, '0, 0, 0, 0);
    run_op("r_post","R", 32'h0000_0040, '0, 2'b00, 2'b00, 6, D1, 0, 0, 1);

    // Unknown op code: one-cycle error pulse, no response.
    @(negedge clock);
    opValid = 1'b1; operation = "X"; address = 32'h0000_0040;
    @(posedge clock);
    #1;
    opValid = 1'b0; operation = 8'h00;
    chk("x_err", opError, 1);
    chk("x_ready", opReady, 1);
    chk("x_valid", respValid, 0);
    @(posedge clock);
    #1;
    chk("x_err_fall", opError, 0);
    nresp = 0;
    repeat (8) begin
      @(posedge clock);
      #1;
      if (respValid) nresp++;
    end
    chk("x_no_resp", nresp, 0);

    run_op("w_alias", "W", 32'h0000_0400, D2, 2'b00, 2'b00, 4, '0, 0, 0, 1);
    run_op("r_alias", "R", 32'h0000_0000, '0, 2'b00, 2'b00, 6, D2, 0, 0, 1);
    run_op("r_keep",  "R", 32'h0000_0040, '0, 2'b00, 2'b00, 6, D1, 0, 0, 1);

    // Reset three cycles into a writeback aborts it.
    @(negedge clock);
    opValid = 1'b1; operation = "W"; address = 32'h0000_0080; writeData = D3;
    @(posedge clock);
    #1;
    opValid = 1'b0;
    repeat (3) @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    chk("rstmid_ready", opReady, 1);
    chk("rstmid_valid", respValid, 0);
    @(negedge clock);
    reset = 1'b0;
    nresp = 0;
    repeat (8) begin
      @(posedge clock);
      #1;
      if (respValid) nresp++;
    end
    chk("rstmid_no_resp", nresp, 0);
    run_op("r_abort", "R", 32'h0000_0080, '0, 2'b00, 2'b00, 6, '0, 0, 0, 1);
    run_op("r_clr",   "R", 32'h0000_0040, '0, 2'b00, 2'b00, 6, '0, 0, 0, 1);

    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
